// File: rtl/rr_decode_arbiter_if.sv
// Requester-side bus of the round-robin decode arbiter: request/enable/done in, grant out.
interface rr_decode_arbiter_if;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       IDLE;

  modport master (
    output enable, req, done,
    input  grant, grant_idx, grant_valid, IDLE
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_idx, grant_valid, IDLE
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters driving the index/enable of a shared 3-to-8 decode,
// with a per-owner hold limit under contention and back-to-back handover.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decode_arbiter_if.slave   bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_grant;
  logic [2:0]       r_idx;
  logic             r_valid;
  logic             r_idle;

  logic [7:0]       w_others;
  logic             w_timeout;
  logic             w_release;
  logic [2:0]       w_next_ptr;
  logic [2:0]       w_new_idx;
  logic [2:0]       w_hand_idx;

  // Scan downward so the lowest offset from p is the one left standing.
  function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] m);
    logic [2:0] idx;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (m[idx]) pick = idx;
    end
  endfunction

  assign w_others   = bus.req & ~(8'b1 << r_idx);
  assign w_timeout  = (r_cnt == HOLD_LAST) && (|w_others);
  assign w_release  = bus.done || !bus.req[r_idx] || w_timeout;
  assign w_next_ptr = r_idx + 3'd1;
  assign w_new_idx  = pick(r_ptr, bus.req);
  assign w_hand_idx = pick(w_next_ptr, w_others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b1;
    end else if (!bus.enable) begin
      // Shutdown still rotates priority past an owner that was cut off.
      if (r_state == S_GRANT) r_ptr <= w_next_ptr;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state <= S_GRANT;
            r_idx   <= w_new_idx;
            r_grant <= 8'b1 << w_new_idx;
            r_valid <= 1'b1;
            r_idle  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (!w_release) begin
            if (r_cnt != HOLD_LAST) r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_ptr <= w_next_ptr;
            r_cnt <= '0;
            if (|w_others) begin
              r_idx   <= w_hand_idx;
              r_grant <= 8'b1 << w_hand_idx;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_idle  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_idx;
  assign bus.grant_valid = r_valid;
  assign bus.IDLE        = r_idle;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: reset, rotation, hold-limit, wrap, enable drop, async reset.
module tb_rr_decode_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rr_decode_arbiter_if bus();

  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] idx);
    logic [7:0] onehot;
    onehot = 8'b1 << idx;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(onehot));
    chk({tag, ".idx"},   32'(bus.grant_idx), 32'(idx));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'd1);
    chk({tag, ".IDLE"},  32'(bus.IDLE), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".grant"}, 32'(bus.grant), 32'h00);
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'd0);
    chk({tag, ".IDLE"},  32'(bus.IDLE), 32'd1);
  endtask

  initial begin
    logic [2:0] tmo_seq [8];
    n_chk  = 0;
    n_fail = 0;
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.req    = 8'hFF;
    bus.done   = 1'b0;
    step();
    step();
    expect_idle("reset");

    rst = 1'b0;
    step();
    expect_grant("first", 3'd0);

    // Rotation with done every cycle: 1..7 then 0, no bubbles.
    bus.done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_grant($sformatf("rot%0d", k), 3'((k + 1) % 8));
    end
    bus.done = 1'b0;

    // Hold limit: owner 0 already visible one cycle.
    bus.req = 8'h05;
    tmo_seq = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
    for (int k = 0; k < 8; k++) begin
      step();
      expect_grant($sformatf("tmo%0d", k), tmo_seq[k]);
    end

    // Lone requester keeps the grant without timeout.
    bus.req = 8'h10;
    for (int k = 0; k < 22; k++) begin
      step();
      chk($sformatf("lone%0d", k), 32'(bus.grant), 32'h10);
    end

    // Wrap priority: owner 6 releases, ptr=7.
    bus.req = 8'h40;
    step();
    expect_grant("to6", 3'd6);
    bus.req = 8'h81;
    step();
    expect_grant("wrap7", 3'd7);
    bus.done = 1'b1;
    step();
    expect_grant("wrap0", 3'd0);
    bus.done = 1'b0;

    // Enable drop with owner 3, then resume from ptr=4.
    bus.req = 8'h08;
    step();
    expect_grant("to3", 3'd3);
    bus.enable = 1'b0;
    step();
    expect_idle("endrop");
    bus.enable = 1'b1;
    bus.req    = 8'h18;
    step();
    expect_grant("resume4", 3'd4);

    // Async reset between edges while owner 5 holds.
    bus.req = 8'h20;
    step();
    expect_grant("to5", 3'd5);
    #2;
    rst = 1'b1;
    #1;
    expect_idle("asyncrst");
    bus.req = 8'h22;
    step();
    rst = 1'b0;
    step();
    expect_grant("postrst", 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one resource among 8 requesters; the resource is selected by a 3-bit index.
- Drives the 3-bit index and enable of the shared 3-to-8 decode path.
- Also outputs a registered one-hot grant vector and an IDLE flag.
- Adds fairness rotation, a grant-hold limit and a clean enable shutdown around the decode.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
- CNT_W, 4: width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  arbiter enable; 0 forces release and no new grants
- req  input  8  request per requester, level-sensitive
- done  input  1  the current owner signals completion; sampled only in GRANT state
- grant  output  8  registered one-hot grant; all-zero when idle
- grant_idx  output  3  binary index of the owner; valid when grant_valid=1
- grant_valid  output  1  a grant is active
- IDLE  output  1  1 when grant_valid=0

Behaviour:
- States: S_IDLE, S_GRANT. Internal registers:
  - ptr[2:0]: index with highest priority.
  - cnt[CNT_W-1:0]: cycles the current grant has been held.
- Reset, asynchronous, effective immediately:
  - state=S_IDLE, ptr=0, cnt=0.
  - grant=8'h00, grant_idx=0, grant_valid=0, IDLE=1.
- Arbitration function pick(ptr, mask): first index i scanning ptr, ptr+1, ..., ptr+7 (mod 8) with mask[i]=1.
- S_IDLE:
  - If enable=1 and |req=1: on the next edge go to S_GRANT.
    - grant_idx=pick(ptr, req); grant=1<<grant_idx; grant_valid=1; cnt=0.
  - Latency from req sampled to grant visible: 1 cycle.
- S_GRANT, owner o=grant_idx. Release condition R, evaluated each cycle, is any of:
  - done=1
  - req[o]=0
  - cnt==MAX_HOLD-1 and (req & ~(1<<o))!=0, i.e. timeout while others wait
- S_GRANT when R=0: hold the grant; cnt increments and saturates at MAX_HOLD-1.
- S_GRANT when R=1:
  - ptr <= o+1 (mod 8).
  - Let m = req with bit o cleared.
  - If enable=1 and m!=0: grant pick(o+1, m) on the next edge. This is a back-to-back handover with no bubble; cnt=0.
  - Else: go to S_IDLE next edge; grant=0, grant_valid=0.
- Owner never wins twice in a row when others are pending. A lone requester with req held and done=0 keeps the grant indefinitely; there is no timeout without contention.
- enable=0 in any state: next edge goes to S_IDLE, grant cleared, cnt=0. ptr retained; it advances to o+1 if a grant was active.
- Simultaneous done=1 and timeout: treated as a single release.
- req changes of non-owners never disturb the current grant.
- Invariants:
  - grant is always zero or one-hot.
  - grant == (grant_valid ? 1<<grant_idx : 0).
  - IDLE == ~grant_valid.
- Reset asserted mid-grant: outputs clear asynchronously. After release, arbitration restarts from ptr=0.

Test Plan:
- Reset: rst=1 with req=8'hFF -> grant=00, grant_valid=0, IDLE=1. Release rst, enable=1 -> next cycle grant=8'h01, grant_idx=0.
- Rotation: req=8'hFF, pulse done every cycle -> grant_idx sequence 0,1,2,...,7,0 with no idle cycles.
- Timeout: MAX_HOLD=4, req=8'h05 held, done=0 -> idx 0 for 4 cycles, then idx 2 for 4 cycles, then idx 0. Lone req=8'h10 -> grant 8'h10 held more than 20 cycles.
- Wrap priority: ptr at 7 after owner 6 releases, req=8'h81 -> grant idx 7. Next release -> idx 0.
- Enable drop: grant_idx=3 active, enable=0 -> next cycle grant=0, IDLE=1. enable=1 with req=8'h18 -> grant idx 4, since ptr=4.
- Async reset mid-grant: assert rst between clock edges while grant=8'h20 -> outputs 0 before the next edge. After reset, req=8'h22 -> idx 1.
